code_packer: RTL

Streaming bit packer for the compression datapath. Accepts one variable-length code per handshake, masks it to its length, appends it LSB-first into an accumulator and emits fixed-width output words with valid/ready flow control. A flush request drains the accumulator and marks the final, possibly partial, word. It generalises the two-input fixed merge stage to an arbitrary code sequence with backpressure.

---
 rtl/code_packer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/code_packer.sv
// Streaming LSB-first bit packer: variable-length codes in, fixed-width words out.
// Optional `bitCount` output enabled with PACKER_BIT_COUNT_EN.
module code_packer #(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned LEN_WIDTH = 6,
   parameter int unsigned OUT_WIDTH = 64
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             inValid,
   output logic                             inReady,
   input  logic [IN_WIDTH-1:0]              dataIn,
   input  logic [LEN_WIDTH-1:0]             inLen,
   input  logic                             flush,
   output logic                             outValid,
   input  logic                             outReady,
   output logic [OUT_WIDTH-1:0]             dataOut,
   output logic [$clog2(OUT_WIDTH+1)-1:0]   outLen,
   output logic                             outLast
`ifdef PACKER_BIT_COUNT_EN
   ,output logic [31:0]                     bitCount
`endif
);

   localparam int unsigned ACC_WIDTH  = OUT_WIDTH + IN_WIDTH;
   localparam int unsigned FILL_WIDTH = $clog2(ACC_WIDTH + 1);
   localparam int unsigned OLEN_WIDTH = $clog2(OUT_WIDTH + 1);

   localparam logic [FILL_WIDTH-1:0] OUT_FILL   = FILL_WIDTH'(OUT_WIDTH);
   localparam logic [LEN_WIDTH-1:0]  IN_LEN_MAX = LEN_WIDTH'(IN_WIDTH);
   localparam logic [OLEN_WIDTH-1:0] OUT_LEN    = OLEN_WIDTH'(OUT_WIDTH);

   typedef enum logic {ST_PACK, ST_FLUSH} state_e;

   state_e                  state_q, state_d;
   logic [ACC_WIDTH-1:0]    acc_q, acc_d;
   logic [FILL_WIDTH-1:0]   fill_q, fill_d;
   logic                    out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]    data_out_q, data_out_d;
   logic [OLEN_WIDTH-1:0]   out_len_q, out_len_d;
   logic                    out_last_q, out_last_d;

   logic [LEN_WIDTH-1:0]    eff_len;
   logic [FILL_WIDTH-1:0]   code_len;
   logic [IN_WIDTH-1:0]     code_masked;
   logic [ACC_WIDTH-1:0]    acc_base;
   logic [FILL_WIDTH-1:0]   fill_base;
   logic                    fill_full;
   logic                    slot_free;
   logic                    in_ready;
   logic                    accept;

   // Clamp the length, then zero every code bit at or above it.
   always_comb begin
      eff_len     = (inLen > IN_LEN_MAX) ? IN_LEN_MAX : inLen;
      code_len    = FILL_WIDTH'(eff_len);
      code_masked = '0;
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
         code_masked[i] = dataIn[i] & (i < 32'(eff_len));
      end
   end

   // inReady depends only on registered state, never on outReady.
   assign fill_full = (fill_q >= OUT_FILL);
   assign slot_free = !out_valid_q || outReady;
   assign in_ready  = (state_q == ST_PACK) && (!fill_full || !out_valid_q);
   assign accept    = inValid && in_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      fill_d      = fill_q;
      out_valid_d = out_valid_q && !outReady;
      data_out_d  = data_out_q;
      out_len_d   = out_len_q;
      out_last_d  = out_last_q;
      acc_base    = acc_q;
      fill_base   = fill_q;

      case (state_q)
         ST_PACK: begin
            if (fill_full && slot_free) begin
               out_valid_d = 1'b1;
               data_out_d  = acc_q[OUT_WIDTH-1:0];
               out_len_d   = OUT_LEN;
               out_last_d  = 1'b0;
               acc_base    = acc_q >> OUT_WIDTH;
               fill_base   = fill_q - OUT_FILL;
            end
            // A code accepted alongside an emission lands on the post-shift base.
            acc_d  = acc_base;
            fill_d = fill_base;
            if (accept) begin
               acc_d  = acc_base | (ACC_WIDTH'(code_masked) << fill_base);
               fill_d = fill_base + code_len;
            end
            if (flush) begin
               state_d = ST_FLUSH;
            end
         end

         ST_FLUSH: begin
            if (slot_free) begin
               out_valid_d = 1'b1;
               data_out_d  = acc_q[OUT_WIDTH-1:0];
               if (fill_q > OUT_FILL) begin
                  out_len_d  = OUT_LEN;
                  out_last_d = 1'b0;
                  acc_d      = acc_q >> OUT_WIDTH;
                  fill_d     = fill_q - OUT_FILL;
               end else begin
                  // Bits above fill are always zero, so an empty drain yields dataOut=0.
                  out_len_d  = OLEN_WIDTH'(fill_q);
                  out_last_d = 1'b1;
                  acc_d      = '0;
                  fill_d     = '0;
                  state_d    = ST_PACK;
               end
            end
         end

         default: state_d = ST_PACK;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_PACK;
         acc_q       <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         out_len_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         out_len_q   <= out_len_d;
         out_last_q  <= out_last_d;
      end
   end

   assign inReady  = in_ready;
   assign outValid = out_valid_q;
   assign dataOut  = data_out_q;
   assign outLen   = out_len_q;
   assign outLast  = out_last_q;

`ifdef PACKER_BIT_COUNT_EN
   logic [31:0] bit_count_q, bit_count_d;

   always_comb begin
      bit_count_d = bit_count_q;
      if (accept) begin
         bit_count_d = bit_count_q + 32'(eff_len);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_count_q <= '0;
      end else begin
         bit_count_q <= bit_count_d;
      end
   end

   assign bitCount = bit_count_q;
`endif

endmodule
